bus_arbiter_rr: RTL and testbench

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

---
 rtl/bus_arbiter_rr.sv | 159 +++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr
//   Round-robin arbiter that connects NUM_MASTERS request/response masters to
//   one slave port. Arbitration takes one cycle: a grant is registered in
//   IDLE, and the granted master's request is passed straight through to the
//   slave while BUSY. A transfer completes on s_valid && s_ready.
//
//   Optional feature macro: BUS_TIMEOUT_EN
//     When defined, a stall counter aborts a transfer after TIMEOUT_CYCLES
//     consecutive BUSY cycles without s_ready. The abort pulses m_ready[g] and
//     m_err together. When undefined, the arbiter waits for s_ready without a
//     limit, and m_err is tied low.
//
// Ports
//   clk, reset           : clock, asynchronous active-high reset
//   m_valid / m_write    : per-master request and direction (1 = write)
//   m_addr / m_wdata     : packed per-master address / write data (slice i)
//   m_ready              : per-master completion strobe (one cycle)
//   m_rdata              : shared read data, zero unless an m_ready bit is set
//   m_grant              : one-hot current owner, zero in IDLE
//   m_err                : timeout-abort strobe
//   s_valid/s_write/s_addr/s_wdata : request to the slave
//   s_ready / s_rdata    : slave completion and read data
// ---------------------------------------------------------------------------
module bus_arbiter_rr #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            m_valid,
  input  logic [NUM_MASTERS-1:0]            m_write,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]            m_ready,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]            m_grant,
  output logic                              m_err,
  output logic                              s_valid,
  output logic                              s_write,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  input  logic                              s_ready,
  input  logic [DATA_WIDTH-1:0]             s_rdata
);

  localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                 r_state;
  logic [IW-1:0]          r_gidx;   // index of the current owner
  logic [IW-1:0]          r_last;   // index of the last completed owner

  logic                   w_busy;
  logic                   w_gvalid;
  logic                   w_sv_raw;
  logic                   w_timeout;
  logic                   w_done;
  logic                   w_any;
  logic [IW-1:0]          w_pick;
  logic [IW-1:0]          w_idx;
  logic [NUM_MASTERS-1:0] w_onehot;

  // Round-robin search: start just above the last owner and wrap around, so
  // the most recently served master is considered last.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_last;
    w_idx  = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      w_idx = IW'((32'(r_last) + i) % NUM_MASTERS);
      if (!w_any && m_valid[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  always_comb begin
    w_onehot         = '0;
    w_onehot[r_gidx] = 1'b1;
  end

  assign w_busy   = (r_state == ST_BUSY);
  assign w_gvalid = m_valid[r_gidx];
  assign w_sv_raw = w_busy && w_gvalid;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  // r_cnt holds the stalls already seen, so this cycle is stall number
  // r_cnt+1; the abort fires when that reaches TIMEOUT_CYCLES.
  assign w_timeout = w_sv_raw && !s_ready && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_sv_raw && !s_ready && !w_timeout) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_timeout        = 1'b0;
`endif

  // Slave side: pure pass-through of the owner's request while BUSY.
  assign s_valid = w_sv_raw && !w_timeout;
  assign s_write = w_busy ? m_write[r_gidx] : 1'b0;
  assign s_addr  = w_busy ? m_addr[r_gidx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign s_wdata = w_busy ? m_wdata[r_gidx*DATA_WIDTH +: DATA_WIDTH] : '0;

  assign w_done  = s_valid && s_ready;

  // Master side: ready only ever reaches the owner; data only with ready.
  assign m_grant = w_busy ? w_onehot : '0;
  assign m_ready = (w_done || w_timeout) ? w_onehot : '0;
  assign m_rdata = w_done ? s_rdata : '0;
  assign m_err   = w_timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_gidx  <= '0;
      r_last  <= IW'(NUM_MASTERS - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gidx  <= w_pick;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A withdrawn request is abandoned without counting as service.
          if (!w_gvalid) begin
            r_state <= ST_IDLE;
          end else if (w_done || w_timeout) begin
            r_last  <= r_gidx;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
module tb_bus_arbiter_rr;

  localparam int unsigned NM = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;

  logic             clk;
  logic             reset;
  logic [NM-1:0]    m_valid;
  logic [NM-1:0]    m_write;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM-1:0]    m_ready;
  logic [DW-1:0]    m_rdata;
  logic [NM-1:0]    m_grant;
  logic             m_err;
  logic             s_valid;
  logic             s_write;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic             s_ready;
  logic [DW-1:0]    s_rdata;

  bus_arbiter_rr #(
    .NUM_MASTERS   (NM),
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .m_valid (m_valid),
    .m_write (m_write),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ready (m_ready),
    .m_rdata (m_rdata),
    .m_grant (m_grant),
    .m_err   (m_err),
    .s_valid (s_valid),
    .s_write (s_write),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_ready (s_ready),
    .s_rdata (s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NM-1:0] ready;
    logic [DW-1:0] rdata;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference payloads for each master, also used to fill expectations.
  logic [AW-1:0] pa [NM];
  logic [DW-1:0] pd [NM];
  logic          pw [NM];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_payload(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pa[i] = a; pd[i] = d; pw[i] = w;
    m_write[i]          = w;
    m_addr[i*AW +: AW]  = a;
    m_wdata[i*DW +: DW] = d;
  endtask

  task automatic expect_xfer(input int i, input logic [DW-1:0] rd, input logic err);
    exp_t e;
    e.ready    = '0;
    e.ready[i] = 1'b1;
    e.rdata    = rd;
    e.addr     = pa[i];
    e.wdata    = pd[i];
    e.wr       = pw[i];
    e.err      = err;
    sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    reset   = 1'b1;
    m_valid = '0;
    s_ready = 1'b0;
    repeat (2) next_cycle();
    chk("rst_grant", 64'(m_grant), 64'd0);
    chk("rst_svalid", 64'(s_valid), 64'd0);
    chk("rst_ready", 64'(m_ready), 64'd0);
    reset = 1'b0;
  endtask

  // Monitor: pops one expectation per completion strobe.
  always @(negedge clk) begin
    if (!reset) begin
      chk("ready_not_owner", 64'(m_ready & ~m_grant), 64'd0);
      if (m_ready != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", 64'(m_ready), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_ready", 64'(m_ready), 64'(e.ready));
          chk("sb_rdata", 64'(m_rdata), 64'(e.rdata));
          chk("sb_addr", 64'(s_addr), 64'(e.addr));
          chk("sb_wdata", 64'(s_wdata), 64'(e.wdata));
          chk("sb_write", 64'(s_write), 64'(e.wr));
          chk("sb_err", 64'(m_err), 64'(e.err));
        end
      end else begin
        chk("idle_rdata", 64'(m_rdata), 64'd0);
        chk("idle_err", 64'(m_err), 64'd0);
      end
    end
  end

  initial begin
    reset   = 1'b1;
    m_valid = '0;
    m_write = '0;
    m_addr  = '0;
    m_wdata = '0;
    s_ready = 1'b0;
    s_rdata = '0;

    // Single write from master 0.
    do_reset();
    set_payload(0, 1'b1, 16'h0010, 32'hDEADBEEF);
    next_cycle();
    m_valid = 4'b0001; s_ready = 1'b1; s_rdata = 32'h55AA55AA;
    expect_xfer(0, 32'h55AA55AA, 1'b0);
    @(negedge clk);
    chk("t1_c0_svalid", 64'(s_valid), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("t1_c1_svalid", 64'(s_valid), 64'd1);
    chk("t1_c1_grant", 64'(m_grant), 64'h1);
    chk("t1_c1_ready", 64'(m_ready), 64'h1);
    next_cycle();
    m_valid = '0;
    @(negedge clk);
    chk("t1_c2_grant", 64'(m_grant), 64'd0);
    chk("t1_c2_svalid", 64'(s_valid), 64'd0);

    // Round-robin with all four requesting.
    do_reset();
    for (int i = 0; i < 4; i++)
      set_payload(i, i[0], 16'h0100 + 16'(i), 32'hA0000000 + 32'(i));
    next_cycle();
    m_valid = 4'b1111; s_ready = 1'b1; s_rdata = 32'h0000BEEF;
    expect_xfer(0, 32'h0000BEEF, 1'b0);
    expect_xfer(1, 32'h0000BEEF, 1'b0);
    expect_xfer(2, 32'h0000BEEF, 1'b0);
    expect_xfer(3, 32'h0000BEEF, 1'b0);
    expect_xfer(0, 32'h0000BEEF, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      logic [NM-1:0] er;
      next_cycle();
      if (k == 10) m_valid = '0;
      @(negedge clk);
      er = '0;
      if (k % 2 == 1) er[((k - 1) / 2) % 4] = 1'b1;
      chk("t2_rr_ready", 64'(m_ready), 64'(er));
    end

    // Read from master 2 with three stall cycles.
    do_reset();
    set_payload(2, 1'b0, 16'h0200, 32'h0);
    next_cycle();
    m_valid = 4'b0100; s_ready = 1'b0; s_rdata = 32'hCAFEF00D;
    expect_xfer(2, 32'h12345678, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      @(negedge clk);
      chk("t3_stall_svalid", 64'(s_valid), 64'd1);
      chk("t3_stall_ready", 64'(m_ready), 64'd0);
    end
    next_cycle();
    s_ready = 1'b1; s_rdata = 32'h12345678;
    @(negedge clk);
    chk("t3_ready", 64'(m_ready), 64'h4);
    chk("t3_rdata", 64'(m_rdata), 64'h12345678);
    next_cycle();
    m_valid = '0; s_ready = 1'b0;

    // Reset in the middle of a transfer by master 1.
    do_reset();
    for (int i = 0; i < 4; i++)
      set_payload(i, 1'b1, 16'h0300 + 16'(i), 32'hB0000000 + 32'(i));
    next_cycle();
    m_valid = 4'b0010; s_ready = 1'b0; s_rdata = 32'h0BADF00D;
    next_cycle();
    @(negedge clk);
    chk("t4_grant_m1", 64'(m_grant), 64'h2);
    next_cycle();
    reset = 1'b1; s_ready = 1'b1; m_valid = 4'b1111;
    #1;
    chk("t4_rst_grant", 64'(m_grant), 64'd0);
    chk("t4_rst_svalid", 64'(s_valid), 64'd0);
    chk("t4_rst_ready", 64'(m_ready), 64'd0);
    chk("t4_rst_saddr", 64'(s_addr), 64'd0);
    chk("t4_rst_swdata", 64'(s_wdata), 64'd0);
    chk("t4_rst_swrite", 64'(s_write), 64'd0);
    next_cycle();
    reset = 1'b0;
    expect_xfer(0, 32'h0BADF00D, 1'b0);
    @(negedge clk);
    chk("t4_rel_idle", 64'(m_grant), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("t4_first_m0", 64'(m_grant), 64'h1);
    next_cycle();
    m_valid = '0; s_ready = 1'b0;

    // Slave never answers.
    do_reset();
    for (int i = 0; i < 4; i++)
      set_payload(i, 1'b0, 16'h0400 + 16'(i), 32'hC0000000 + 32'(i));
    next_cycle();
    m_valid = 4'b0011; s_ready = 1'b0; s_rdata = 32'h77777777;
`ifdef BUS_TIMEOUT_EN
    expect_xfer(0, 32'h0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      next_cycle();
      if (k == 19) m_valid = '0;
      @(negedge clk);
      if (k <= 16) chk("to_grant_m0", 64'(m_grant), 64'h1);
      if (k < 16)  chk("to_no_err", 64'(m_err), 64'd0);
      if (k == 16) begin
        chk("to_err", 64'(m_err), 64'd1);
        chk("to_ready", 64'(m_ready), 64'h1);
        chk("to_svalid", 64'(s_valid), 64'd0);
      end
      if (k == 17) chk("to_idle", 64'(m_grant), 64'd0);
      if (k == 18) chk("to_next_m1", 64'(m_grant), 64'h2);
      if (k == 20) chk("to_drop_idle", 64'(m_grant), 64'd0);
    end
`else
    for (int k = 1; k <= 102; k++) begin
      next_cycle();
      if (k == 101) m_valid = '0;
      @(negedge clk);
      if (k <= 100) begin
        chk("stall_grant", 64'(m_grant), 64'h1);
        chk("stall_svalid", 64'(s_valid), 64'd1);
        chk("stall_err", 64'(m_err), 64'd0);
        chk("stall_ready", 64'(m_ready), 64'd0);
      end
      if (k == 101) chk("drop_svalid", 64'(s_valid), 64'd0);
      if (k == 102) chk("drop_idle", 64'(m_grant), 64'd0);
    end
`endif

    repeat (2) next_cycle();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
